// File: rtl/pc.sv
`default_nettype none
// ============================================================================
// Module      : pc
// Description : Program counter register for the 8-bit CPU core. Holds the
//               address of the current instruction, advances by a fixed STEP
//               every clock and accepts an absolute jump target via a load
//               path. Control/branch logic drives load_en/d; instruction
//               fetch consumes q.
//
// Ports       : clk      in   1      system clock, rising-edge active
//               reset    in   1      synchronous active-high reset
//               load_en  in   1      load d instead of incrementing
//               d        in   WIDTH  jump/branch target address
//               q        out  WIDTH  current program counter (registered)
//               q_next   out  WIDTH  value q takes at the next rising edge
//               wrap     out  1      increment cycle whose q+STEP overflows
//
// Parameters  : WIDTH       address width in bits
//               RESET_VALUE value loaded on reset (must fit in WIDTH bits)
//               STEP        unsigned increment (must fit in WIDTH bits)
//
// Revision    : 1.0  initial release
// ============================================================================
module pc #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned RESET_VALUE = 0,
    parameter int unsigned STEP        = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next,
    output logic             wrap
);

    // Parameters are truncated to the register width once, here, so every
    // use below is already WIDTH bits wide.
    localparam logic [WIDTH-1:0] c_reset_value = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] c_step        = WIDTH'(STEP);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH:0]   w_sum;      // one extra bit to expose the carry-out
    logic             w_inc_cycle;
    logic [WIDTH-1:0] w_q_next;

    // Widened add: the low WIDTH bits are the modulo-2^WIDTH increment, the
    // top bit is the carry used only for the wrap indication.
    assign w_sum       = {1'b0, r_q} + {1'b0, c_step};
    assign w_inc_cycle = ~reset & ~load_en;

    // Next-state selection, reset over load over increment. The register is
    // loaded from this same value, so q always equals the previous q_next.
    always_comb begin
        w_q_next = w_sum[WIDTH-1:0];
        if (reset) begin
            w_q_next = c_reset_value;
        end else if (load_en) begin
            w_q_next = d;
        end
    end

    always_ff @(posedge clk) begin
        r_q <= w_q_next;
    end

    assign q      = r_q;
    assign q_next = w_q_next;
    assign wrap   = w_inc_cycle & w_sum[WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_pc.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc
// Description : Self-checking bench for pc. Directed vectors carry
//               hand-computed expected values; each applied vector pushes an
//               expected record into a scoreboard queue and an independent
//               monitor pops and compares q_next/wrap before the edge and q
//               after it.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pc;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             load_en;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic             wrap;

    int checks;
    int failures;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] exp_qn;
        logic             exp_wrap;
        logic [WIDTH-1:0] exp_q;
    } exp_t;

    exp_t sb[$];

    pc #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(0),
        .STEP       (1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .load_en(load_en),
        .d      (d),
        .q      (q),
        .q_next (q_next),
        .wrap   (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; the expected record describes the
    // combinational outputs for this cycle and q after the coming rising edge.
    task automatic apply(input string name, input logic rst, input logic ld,
                         input logic [WIDTH-1:0] dv, input logic [WIDTH-1:0] qn,
                         input logic wr, input logic [WIDTH-1:0] qa);
        exp_t e;
        @(negedge clk);
        reset   = rst;
        load_en = ld;
        d       = dv;
        e.name     = name;
        e.exp_qn   = qn;
        e.exp_wrap = wr;
        e.exp_q    = qa;
        sb.push_back(e);
    endtask

    // Monitor: compares comb outputs mid-cycle, then q just after the edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                e = sb[0];
                checks++;
                if (q_next !== e.exp_qn) begin
                    failures++;
                    $display("FAIL %s q_next: got %0d expected %0d", e.name, q_next, e.exp_qn);
                end
                checks++;
                if (wrap !== e.exp_wrap) begin
                    failures++;
                    $display("FAIL %s wrap: got %0b expected %0b", e.name, wrap, e.exp_wrap);
                end
                @(posedge clk);
                #1;
                checks++;
                if (q !== e.exp_q) begin
                    failures++;
                    $display("FAIL %s q: got %0d expected %0d", e.name, q, e.exp_q);
                end
                void'(sb.pop_front());
            end
        end
    end

    initial begin : stimulus
        int budget;
        reset   = 1'b1;
        load_en = 1'b0;
        d       = '0;
        checks  = 0;
        failures = 0;

        //     name          rst  ld  d    q_next wrap q_after
        apply("reset",       1, 0, 0,   0,   0, 0);
        apply("inc1",        0, 0, 0,   1,   0, 1);
        apply("inc2",        0, 0, 0,   2,   0, 2);
        apply("load100",     0, 1, 100, 100, 0, 100);
        apply("inc101",      0, 0, 0,   101, 0, 101);
        apply("inc102",      0, 0, 0,   102, 0, 102);
        apply("load254",     0, 1, 254, 254, 0, 254);
        apply("inc255",      0, 0, 0,   255, 0, 255);
        apply("wrap0",       0, 0, 0,   0,   1, 0);
        apply("inc_after",   0, 0, 0,   1,   0, 1);
        apply("load100b",    0, 1, 100, 100, 0, 100);
        apply("load_same",   0, 1, 100, 100, 0, 100);
        apply("rst_over_ld", 1, 1, 100, 0,   0, 0);
        apply("rst_hold",    1, 0, 0,   0,   0, 0);
        apply("rst_release", 0, 0, 0,   1,   0, 1);
        apply("load10",      0, 1, 10,  10,  0, 10);
        apply("load20",      0, 1, 20,  20,  0, 20);
        apply("load30",      0, 1, 30,  30,  0, 30);
        apply("load255",     0, 1, 255, 255, 0, 255);
        apply("ld_at_255",   0, 1, 5,   5,   0, 5);
        apply("load255b",    0, 1, 255, 255, 0, 255);
        apply("rst_at_255",  1, 0, 0,   0,   0, 0);

        @(negedge clk);
        load_en = 1'b0;
        reset   = 1'b0;
        budget  = 0;
        while (sb.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d records left, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc.md
Name: pc

Overview:
- Program counter register for the 8-bit CPU core.
- Holds the address of the current instruction and advances by a fixed step every clock.
- Accepts an absolute jump target through a load path.
- Sits between the control/branch logic, which drives load_en and d, and instruction fetch, which consumes q.

Parameters:
- WIDTH, 8, bit width of the address register, the load data and all address outputs.
- RESET_VALUE, 0, value loaded into q on reset; must fit in WIDTH bits.
- STEP, 1, increment applied each non-load, non-reset cycle; treated as unsigned; must fit in WIDTH bits.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- load_en  input  1  when high, q takes d at the next rising edge instead of incrementing.
- d  input  WIDTH  jump/branch target address, sampled only when load_en=1.
- q  output  WIDTH  current program counter value, driven directly from the register.
- q_next  output  WIDTH  combinational value q will take at the next rising edge, given the current reset, load_en and d.
- wrap  output  1  combinational; high when the current cycle is an increment cycle (reset=0, load_en=0) and q+STEP overflows WIDTH bits.

Behaviour:
- Single register q, updated only on the rising edge of clk. No asynchronous paths into q.
- Priority at each rising edge, highest first:
  - reset=1: q <= RESET_VALUE. load_en and d are ignored.
  - load_en=1: q <= d.
  - Otherwise: q <= (q + STEP) mod 2^WIDTH.
- Latency: a load or reset takes effect on q at the first rising edge where it is sampled high. The following edge resumes incrementing from the new value, e.g. load 100 then increment gives 100, 101, 102.
- Wrap-around: with WIDTH=8 and STEP=1, q=255 increments to 0. wrap=1 during the cycle q=255 with no load and no reset. No saturation and no error flag.
- load_en=1 with d equal to the current q: q holds that value for the cycle, with no increment.
- Reset asserted mid-sequence, including while load_en=1: the next edge gives RESET_VALUE regardless of the other inputs.
- Reset held for several cycles: q stays at RESET_VALUE. The first edge after reset falls increments to RESET_VALUE+STEP, unless load_en=1.
- Before the first reset edge, q is undefined. No initial value is required; q is defined from the first reset edge onward.
- q_next is purely combinational from reset, load_en, d and q, using the same priority and arithmetic. q equals the previous cycle's q_next after every edge.
- All arithmetic is unsigned and truncated to WIDTH bits. The carry-out of q+STEP is used only for wrap.
- No handshake; load_en is a single-cycle qualifier and may be held high for consecutive cycles, loading d each cycle.

Test Plan:
- Clock with 10 ns period. reset=1, load_en=0, d=0 for one edge -> q=0, q_next=0.
- Release reset, load_en=0 for two edges -> q goes 1 then 2; q_next=q+1 between edges; wrap=0.
- load_en=1, d=100 for one edge, then load_en=0 for two edges -> q goes 100, 101, 102.
- Load d=254, then increment for three edges:
  - q goes 255, 0, 1.
  - wrap=1 only while q=255.
  - q_next=0 while q=255.
- Hold load_en=1 with d=100, then assert reset=1 -> the next edge gives q=0, confirming reset has priority over load.
- Hold load_en=1 for three edges with d=10, 20, 30 -> q goes 10, 20, 30 with no increments between loads.
